// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-subset controller: states, opcodes, mux selects.
// Latency: none (declarations only).
// Backpressure: n/a.
package mips_ctrl_pkg;

   // Controller states
   typedef enum logic [3:0] {
      FETCH,
      DECODE,
      EXEC_R,
      EXEC_I,
      ALU_WB,
      MEM_ADDR,
      MEM_RD,
      MEM_WB,
      MEM_WR,
      BRANCH,
      JUMP,
      TRAP
   } state_t;

   // Instruction classes produced by the decoder
   localparam logic [2:0] CLS_R   = 3'd0;
   localparam logic [2:0] CLS_I   = 3'd1;
   localparam logic [2:0] CLS_MEM = 3'd2;
   localparam logic [2:0] CLS_BR  = 3'd3;
   localparam logic [2:0] CLS_J   = 3'd4;
   localparam logic [2:0] CLS_JR  = 3'd5;
   localparam logic [2:0] CLS_ILL = 3'd6;

   // Opcodes (instr[31:26])
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // R-type function codes (instr[5:0])
   localparam logic [5:0] FN_JR  = 6'h08;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_SLT = 6'h2A;

   // ALU operation
   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_SLT = 3'd2;
   localparam logic [2:0] ALU_XOR = 3'd3;

   // ALU B operand select
   localparam logic [1:0] SRCB_REG    = 2'd0;
   localparam logic [1:0] SRCB_FOUR   = 2'd1;
   localparam logic [1:0] SRCB_IMM    = 2'd2;
   localparam logic [1:0] SRCB_IMM_SH = 2'd3;

   // Register write address select
   localparam logic [1:0] RDST_RT  = 2'd0;
   localparam logic [1:0] RDST_RD  = 2'd1;
   localparam logic [1:0] RDST_R31 = 2'd2;

   // Register write data select
   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_PC  = 2'd2;

   // Next PC select
   localparam logic [1:0] PC_ALU    = 2'd0;
   localparam logic [1:0] PC_ALUOUT = 2'd1;
   localparam logic [1:0] PC_JUMP   = 2'd2;
   localparam logic [1:0] PC_REGA   = 2'd3;

endpackage

// File: rtl/ctrl_decode.sv
// Instruction decoder: opcode/funct -> class, ALU op, extension mode, illegal flag.
// Latency: purely combinational.
// Backpressure: none; the instruction register holds the inputs stable.
module ctrl_decode
   import mips_ctrl_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output logic [2:0] cls,
   output logic [2:0] alu_op,
   output logic       ext_sel,
   output logic       is_load,
   output logic       is_bne,
   output logic       is_link,
   output logic       illegal
);

   // Map the instruction fields onto a class plus the per-instruction details the FSM needs
   always_comb begin
      cls     = CLS_ILL;
      alu_op  = ALU_ADD;
      ext_sel = 1'b1;
      is_load = 1'b0;
      is_bne  = 1'b0;
      is_link = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               FN_ADD:  cls = CLS_R;
               FN_SUB:  begin cls = CLS_R; alu_op = ALU_SUB; end
               FN_SLT:  begin cls = CLS_R; alu_op = ALU_SLT; end
               FN_JR:   cls = CLS_JR;
               default: cls = CLS_ILL;
            endcase
         end
         OP_ADDI: cls = CLS_I;
         OP_XORI: begin cls = CLS_I; alu_op = ALU_XOR; ext_sel = 1'b0; end
         OP_LW:   begin cls = CLS_MEM; is_load = 1'b1; end
         OP_SW:   cls = CLS_MEM;
         OP_BEQ:  cls = CLS_BR;
         OP_BNE:  begin cls = CLS_BR; is_bne = 1'b1; end
         OP_J:    cls = CLS_J;
         OP_JAL:  begin cls = CLS_J; is_link = 1'b1; end
         default: cls = CLS_ILL;
      endcase
      illegal = (cls == CLS_ILL);
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control FSM driving datapath strobes and mux selects.
// Latency: R/addi/xori/sw 4 cycles, lw 5, branches and jumps 3 (mem_ready high).
// Backpressure: holds in FETCH, MEM_RD and MEM_WR while mem_ready is low.
module multicycle_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int IMM_EXT_WIDTH = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_we,
   output logic       ir_we,
   output logic       reg_we,
   output logic       mem_re,
   output logic       mem_we,
   output logic       iord,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_op,
   output logic       ext_sel,
   output logic [1:0] reg_dst,
   output logic [1:0] wb_src,
   output logic [1:0] pc_src,
   output logic       illegal
);

   // The extender this controller drives only exists in a 32-bit flavour
   if (IMM_EXT_WIDTH != 32) begin : g_width_chk
      $error("multicycle_ctrl: IMM_EXT_WIDTH must be 32");
   end

   state_t     state_q;
   state_t     state_d;
   state_t     out_state;

   logic [2:0] dec_cls;
   logic [2:0] dec_alu_op;
   logic       dec_ext_sel;
   logic       dec_is_load;
   logic       dec_is_bne;
   logic       dec_is_link;
   logic       dec_illegal;

   // The IR holds the instruction for its whole execution, so decode is used live in every state
   ctrl_decode u_decode (
      .opcode  (opcode),
      .funct   (funct),
      .cls     (dec_cls),
      .alu_op  (dec_alu_op),
      .ext_sel (dec_ext_sel),
      .is_load (dec_is_load),
      .is_bne  (dec_is_bne),
      .is_link (dec_is_link),
      .illegal (dec_illegal)
   );

   // Next-state selection
   always_comb begin
      state_d = state_q;
      case (state_q)
         FETCH:    if (mem_ready) state_d = DECODE;
         DECODE: begin
            if (dec_illegal) begin
               state_d = TRAP;
            end else begin
               case (dec_cls)
                  CLS_R:        state_d = EXEC_R;
                  CLS_I:        state_d = EXEC_I;
                  CLS_MEM:      state_d = MEM_ADDR;
                  CLS_BR:       state_d = BRANCH;
                  CLS_J, CLS_JR: state_d = JUMP;
                  default:      state_d = TRAP;
               endcase
            end
         end
         EXEC_R:   state_d = ALU_WB;
         EXEC_I:   state_d = ALU_WB;
         ALU_WB:   state_d = FETCH;
         MEM_ADDR: state_d = dec_is_load ? MEM_RD : MEM_WR;
         MEM_RD:   if (mem_ready) state_d = MEM_WB;
         MEM_WB:   state_d = FETCH;
         MEM_WR:   if (mem_ready) state_d = FETCH;
         BRANCH:   state_d = FETCH;
         JUMP:     state_d = FETCH;
         TRAP:     state_d = TRAP;
         default:  state_d = FETCH;
      endcase
   end

   // State register; reset wins over every transition, including waits and TRAP
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // While reset is asserted the outputs already show the FETCH decode, so no stale
   // memory strobe from an interrupted access leaks out during the reset cycle
   assign out_state = reset ? FETCH : state_q;

   // Output decode; mem_ready (FETCH) and zero (BRANCH) enter as Mealy terms
   always_comb begin
      pc_we     = 1'b0;
      ir_we     = 1'b0;
      reg_we    = 1'b0;
      mem_re    = 1'b0;
      mem_we    = 1'b0;
      iord      = 1'b0;
      alu_src_a = 1'b0;
      alu_src_b = SRCB_REG;
      alu_op    = ALU_ADD;
      ext_sel   = 1'b0;
      reg_dst   = RDST_RT;
      wb_src    = WB_ALU;
      pc_src    = PC_ALU;
      illegal   = 1'b0;
      case (out_state)
         FETCH: begin
            mem_re    = 1'b1;
            alu_src_b = SRCB_FOUR;
            ir_we     = mem_ready;
            pc_we     = mem_ready;
         end
         DECODE: begin
            alu_src_b = SRCB_IMM_SH;
            ext_sel   = 1'b1;
         end
         EXEC_R: begin
            alu_src_a = 1'b1;
            alu_op    = dec_alu_op;
         end
         EXEC_I: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            alu_op    = dec_alu_op;
            ext_sel   = dec_ext_sel;
         end
         ALU_WB: begin
            reg_we  = 1'b1;
            reg_dst = (dec_cls == CLS_R) ? RDST_RD : RDST_RT;
         end
         MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            ext_sel   = 1'b1;
         end
         MEM_RD: begin
            iord   = 1'b1;
            mem_re = 1'b1;
         end
         MEM_WB: begin
            reg_we = 1'b1;
            wb_src = WB_MEM;
         end
         MEM_WR: begin
            iord   = 1'b1;
            mem_we = 1'b1;
         end
         BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_SUB;
            pc_src    = PC_ALUOUT;
            pc_we     = dec_is_bne ? ~zero : zero;
         end
         JUMP: begin
            pc_we  = 1'b1;
            pc_src = (dec_cls == CLS_JR) ? PC_REGA : PC_JUMP;
            if (dec_is_link) begin
               reg_we  = 1'b1;
               reg_dst = RDST_R31;
               wb_src  = WB_PC;
            end
         end
         TRAP: begin
            illegal = 1'b1;
         end
         default: begin
            illegal = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle expected output vectors queued with stimulus.
// Latency: checks every cycle at the falling edge.
// Backpressure: exercises mem_ready stalls and reset during waits.
module tb_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;
   logic       pc_we, ir_we, reg_we, mem_re, mem_we, iord, alu_src_a;
   logic [1:0] alu_src_b;
   logic [2:0] alu_op;
   logic       ext_sel;
   logic [1:0] reg_dst, wb_src, pc_src;
   logic       illegal;

   int tests_run = 0;
   int tests_failed = 0;

   logic [19:0] exp_q[$];
   string       tag_q[$];
   logic [5:0]  cur_op = 6'h00;
   logic [5:0]  cur_fn = 6'h00;

   multicycle_ctrl #(.IMM_EXT_WIDTH(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .opcode    (opcode),
      .funct     (funct),
      .zero      (zero),
      .mem_ready (mem_ready),
      .pc_we     (pc_we),
      .ir_we     (ir_we),
      .reg_we    (reg_we),
      .mem_re    (mem_re),
      .mem_we    (mem_we),
      .iord      (iord),
      .alu_src_a (alu_src_a),
      .alu_src_b (alu_src_b),
      .alu_op    (alu_op),
      .ext_sel   (ext_sel),
      .reg_dst   (reg_dst),
      .wb_src    (wb_src),
      .pc_src    (pc_src),
      .illegal   (illegal)
   );

   always #5 clk = ~clk;

   // Vector order: pc_we ir_we reg_we mem_re mem_we iord a b[2] op[3] ext rdst[2] wb[2] pcs[2] ill
   function automatic logic [19:0] mk(input logic pw, input logic iw, input logic rw,
                                      input logic re, input logic we, input logic io,
                                      input logic a, input logic [1:0] b, input logic [2:0] op,
                                      input logic ext, input logic [1:0] rd, input logic [1:0] wb,
                                      input logic [1:0] pcs, input logic ill);
      return {pw, iw, rw, re, we, io, a, b, op, ext, rd, wb, pcs, ill};
   endfunction

   localparam logic [19:0] F_WAIT = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'd1,3'd0,1'b0,2'd0,2'd0,2'd0,1'b0};
   localparam logic [19:0] F_GO   = {1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'd1,3'd0,1'b0,2'd0,2'd0,2'd0,1'b0};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drive one cycle of stimulus just after the rising edge and queue what the DUT must show
   task automatic step(input string tag, input logic rst, input logic mr, input logic z,
                       input logic [19:0] e);
      @(posedge clk);
      #1;
      reset     = rst;
      mem_ready = mr;
      zero      = z;
      opcode    = cur_op;
      funct     = cur_fn;
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   task automatic set_ins(input logic [5:0] op, input logic [5:0] fn);
      cur_op = op;
      cur_fn = fn;
   endtask

   task automatic fetch_decode();
      step("fetch", 1'b0, 1'b1, 1'b0, F_GO);
      step("decode", 1'b0, 1'b1, 1'b0, mk(0,0,0,0,0,0,0,2'd3,3'd0,1,2'd0,2'd0,2'd0,0));
   endtask

   // Scoreboard side: pop and compare at every falling edge
   initial begin
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            chk(tag_q.pop_front(),
                {12'd0, pc_we, ir_we, reg_we, mem_re, mem_we, iord, alu_src_a, alu_src_b,
                 alu_op, ext_sel, reg_dst, wb_src, pc_src, illegal},
                {12'd0, exp_q.pop_front()});
            chk("re_we_excl", {31'd0, mem_re & mem_we}, 32'd0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; mem_ready = 1'b0; zero = 1'b0; opcode = 6'h00; funct = 6'h00;

      // Reset behaviour and FETCH stall
      step("rst_idle", 1'b1, 1'b0, 1'b0, F_WAIT);
      step("rst_rdy",  1'b1, 1'b1, 1'b0, F_GO);
      step("fetch_stall0", 1'b0, 1'b0, 1'b0, F_WAIT);
      step("fetch_stall1", 1'b0, 1'b0, 1'b0, F_WAIT);

      // R-type: add, sub, slt
      set_ins(6'h00, 6'h20); fetch_decode();
      step("add_exec", 0, 1, 0, mk(0,0,0,0,0,0,1,2'd0,3'd0,0,2'd0,2'd0,2'd0,0));
      step("add_wb",   0, 1, 0, mk(0,0,1,0,0,0,0,2'd0,3'd0,0,2'd1,2'd0,2'd0,0));
      set_ins(6'h00, 6'h22); fetch_decode();
      step("sub_exec", 0, 1, 1, mk(0,0,0,0,0,0,1,2'd0,3'd1,0,2'd0,2'd0,2'd0,0));
      step("sub_wb",   0, 1, 0, mk(0,0,1,0,0,0,0,2'd0,3'd0,0,2'd1,2'd0,2'd0,0));
      set_ins(6'h00, 6'h2A); fetch_decode();
      step("slt_exec", 0, 1, 0, mk(0,0,0,0,0,0,1,2'd0,3'd2,0,2'd0,2'd0,2'd0,0));
      step("slt_wb",   0, 1, 0, mk(0,0,1,0,0,0,0,2'd0,3'd0,0,2'd1,2'd0,2'd0,0));

      // Immediates: addi sign-extends with ADD, xori zero-extends with XOR
      set_ins(6'h08, 6'h15); fetch_decode();
      step("addi_exec", 0, 1, 0, mk(0,0,0,0,0,0,1,2'd2,3'd0,1,2'd0,2'd0,2'd0,0));
      step("addi_wb",   0, 1, 0, mk(0,0,1,0,0,0,0,2'd0,3'd0,0,2'd0,2'd0,2'd0,0));
      set_ins(6'h0E, 6'h2A); fetch_decode();
      step("xori_exec", 0, 1, 0, mk(0,0,0,0,0,0,1,2'd2,3'd3,0,2'd0,2'd0,2'd0,0));
      step("xori_wb",   0, 1, 0, mk(0,0,1,0,0,0,0,2'd0,3'd0,0,2'd0,2'd0,2'd0,0));

      // lw with two wait cycles in MEM_RD
      set_ins(6'h23, 6'h00); fetch_decode();
      step("lw_addr", 0, 1, 0, mk(0,0,0,0,0,0,1,2'd2,3'd0,1,2'd0,2'd0,2'd0,0));
      step("lw_rd0",  0, 0, 0, mk(0,0,0,1,0,1,0,2'd0,3'd0,0,2'd0,2'd0,2'd0,0));
      step("lw_rd1",  0, 0, 0, mk(0,0,0,1,0,1,0,2'd0,3'd0,0,2'd0,2'd0,2'd0,0));
      step("lw_rd2",  0, 1, 0, mk(0,0,0,1,0,1,0,2'd0,3'd0,0,2'd0,2'd0,2'd0,0));
      step("lw_wb",   0, 1, 0, mk(0,0,1,0,0,0,0,2'd0,3'd0,0,2'd0,2'd1,2'd0,0));

      // sw without wait
      set_ins(6'h2B, 6'h00); fetch_decode();
      step("sw_addr", 0, 1, 0, mk(0,0,0,0,0,0,1,2'd2,3'd0,1,2'd0,2'd0,2'd0,0));
      step("sw_wr",   0, 1, 0, mk(0,0,0,0,1,1,0,2'd0,3'd0,0,2'd0,2'd0,2'd0,0));

      // Branches: all four zero/opcode combinations
      set_ins(6'h04, 6'h00); fetch_decode();
      step("beq_z1", 0, 1, 1, mk(1,0,0,0,0,0,1,2'd0,3'd1,0,2'd0,2'd0,2'd1,0));
      fetch_decode();
      step("beq_z0", 0, 1, 0, mk(0,0,0,0,0,0,1,2'd0,3'd1,0,2'd0,2'd0,2'd1,0));
      set_ins(6'h05, 6'h00); fetch_decode();
      step("bne_z1", 0, 1, 1, mk(0,0,0,0,0,0,1,2'd0,3'd1,0,2'd0,2'd0,2'd1,0));
      fetch_decode();
      step("bne_z0", 0, 1, 0, mk(1,0,0,0,0,0,1,2'd0,3'd1,0,2'd0,2'd0,2'd1,0));

      // Jumps: j, jal, jr
      set_ins(6'h02, 6'h00); fetch_decode();
      step("j_jump",   0, 1, 0, mk(1,0,0,0,0,0,0,2'd0,3'd0,0,2'd0,2'd0,2'd2,0));
      set_ins(6'h03, 6'h00); fetch_decode();
      step("jal_jump", 0, 1, 0, mk(1,0,1,0,0,0,0,2'd0,3'd0,0,2'd2,2'd2,2'd2,0));
      set_ins(6'h00, 6'h08); fetch_decode();
      step("jr_jump",  0, 1, 0, mk(1,0,0,0,0,0,0,2'd0,3'd0,0,2'd0,2'd0,2'd3,0));

      // Illegal opcode: TRAP is absorbing for 10 cycles, then reset recovers
      set_ins(6'h3F, 6'h00); fetch_decode();
      for (int i = 0; i < 10; i++) begin
         step("trap_hold", 0, i[0], i[1], mk(0,0,0,0,0,0,0,2'd0,3'd0,0,2'd0,2'd0,2'd0,1));
      end
      step("trap_rst",   1, 0, 0, F_WAIT);
      step("trap_after", 0, 0, 0, F_WAIT);

      // Illegal funct under R-type opcode
      set_ins(6'h00, 6'h3F); fetch_decode();
      step("trap_fn", 0, 1, 0, mk(0,0,0,0,0,0,0,2'd0,3'd0,0,2'd0,2'd0,2'd0,1));
      step("trap_fn_rst",   1, 1, 0, F_GO);
      step("trap_fn_after", 0, 0, 0, F_WAIT);

      // Reset during an MEM_WR wait
      set_ins(6'h2B, 6'h00); fetch_decode();
      step("swr_addr", 0, 1, 0, mk(0,0,0,0,0,0,1,2'd2,3'd0,1,2'd0,2'd0,2'd0,0));
      step("swr_wait", 0, 0, 0, mk(0,0,0,0,1,1,0,2'd0,3'd0,0,2'd0,2'd0,2'd0,0));
      step("swr_rst",  1, 0, 0, F_WAIT);
      step("swr_after", 0, 0, 0, F_WAIT);

      // Recovery: a normal add completes after the interrupted store
      set_ins(6'h00, 6'h20); fetch_decode();
      step("add2_exec", 0, 1, 0, mk(0,0,0,0,0,0,1,2'd0,3'd0,0,2'd0,2'd0,2'd0,0));
      step("add2_wb",   0, 1, 0, mk(0,0,1,0,0,0,0,2'd0,3'd0,0,2'd1,2'd0,2'd0,0));

      @(posedge clk);
      @(negedge clk);
      #1;
      chk("drain", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter: IMM_EXT_WIDTH, 32, width of the sign-extender output the controller configures; only 32 is supported.
REQ-002 clk  input  1  rising-edge clock, single clock domain.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 opcode  input  6  instruction bits [31:26] from the instruction register.
REQ-005 funct  input  6  instruction bits [5:0] from the instruction register.
REQ-006 zero  input  1  ALU zero flag.
REQ-007 mem_ready  input  1  memory access complete this cycle.
REQ-008 pc_we, ir_we, reg_we, mem_re, mem_we  output  1 each  register/memory write and read strobes.
REQ-009 iord  output  1  memory address source: 0 = PC, 1 = ALU result register.
REQ-010 alu_src_a  output  1  ALU A operand: 0 = PC, 1 = reg A.
REQ-011 alu_src_b  output  2  ALU B operand: 0 = reg B, 1 = constant 4, 2 = extended immediate, 3 = extended immediate << 2.
REQ-012 alu_op  output  3  ALU operation: 0 = ADD, 1 = SUB, 2 = SLT, 3 = XOR.
REQ-013 ext_sel  output  1  immediate extension: 1 = sign extend, 0 = zero extend.
REQ-014 reg_dst  output  2  register write address: 0 = rt, 1 = rd, 2 = r31.
REQ-015 wb_src  output  2  register write data: 0 = ALU result, 1 = memory data, 2 = PC.
REQ-016 pc_src  output  2  next PC: 0 = ALU output, 1 = ALU result register (branch target), 2 = jump target, 3 = reg A.
REQ-017 illegal  output  1  an unsupported instruction was decoded.

Function
REQ-018 States: FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP, TRAP.
REQ-019 FETCH: mem_re=1, iord=0, alu_src_a=0, alu_src_b=1, ADD; the state holds while mem_ready=0; when mem_ready=1, ir_we=1, pc_we=1, pc_src=0, and the next state is DECODE.
REQ-020 DECODE: alu_src_a=0, alu_src_b=3, ADD, ext_sel=1 (precomputes the branch target); no strobes; the next state is chosen by opcode.
REQ-021 Decode map: 0x00 (funct 0x20/0x22/0x2A) -> EXEC_R; 0x00 (funct 0x08, jr) -> JUMP; 0x08 addi, 0x0E xori -> EXEC_I; 0x23 lw, 0x2B sw -> MEM_ADDR; 0x04 beq, 0x05 bne -> BRANCH; 0x02 j, 0x03 jal -> JUMP; all other opcodes and funct codes -> TRAP.
REQ-022 EXEC_R: alu_src_a=1, alu_src_b=0; alu_op = ADD, SUB or SLT per funct; next state ALU_WB with reg_dst=1.
REQ-023 EXEC_I: alu_src_a=1, alu_src_b=2; addi uses ADD with ext_sel=1; xori uses XOR with ext_sel=0; next state ALU_WB with reg_dst=0.
REQ-024 ALU_WB: reg_we=1, wb_src=0, reg_dst per originating class; next state FETCH.
REQ-025 MEM_ADDR: alu_src_a=1, alu_src_b=2, ext_sel=1, ADD; lw goes to MEM_RD, sw goes to MEM_WR.
REQ-026 MEM_RD and MEM_WR: iord=1 with mem_re=1 (MEM_RD) or mem_we=1 (MEM_WR); the state holds until mem_ready=1; MEM_RD then goes to MEM_WB, MEM_WR goes to FETCH.
REQ-027 MEM_WB: reg_we=1, wb_src=1, reg_dst=0; next state FETCH.
REQ-028 BRANCH: alu_src_a=1, alu_src_b=0, SUB, pc_src=1; pc_we = zero for beq and ~zero for bne (a Mealy output in this state only); next state FETCH.
REQ-029 JUMP: pc_we=1; pc_src=2 for j/jal and 3 for jr; jal also asserts reg_we=1, reg_dst=2, wb_src=2 (PC already holds PC+4); next state FETCH.
REQ-030 TRAP: illegal=1 and all strobes 0; the state is absorbing until reset.
REQ-031 With mem_ready tied high, latencies are: R/addi/xori 4 cycles, lw 5, sw 4, beq/bne/j/jal/jr 3.
REQ-032 Every strobe not named for a state SHALL be 0; unlisted mux selects SHALL be 0.
REQ-033 mem_re and mem_we SHALL never be asserted in the same cycle.

Reset
REQ-034 When reset=1 at a clock edge, the state SHALL become FETCH; reset has priority over every transition, including mid-memory-wait and TRAP.
REQ-035 During reset and in the first cycle after reset, outputs SHALL equal the FETCH decode, with pc_we=ir_we=0 unless mem_ready=1; illegal=0.

Structure
REQ-036 The state enum, opcode/funct constants, and alu_op, alu_src_b, reg_dst, wb_src and pc_src encodings SHALL reside in the shared package mips_ctrl_pkg.
REQ-037 A combinational sub-module, ctrl_decode (opcode/funct -> instruction class, alu_op, ext_sel, illegal), SHALL be used by the FSM.

Verification
REQ-038 add (opcode 0x00, funct 0x20) with mem_ready=1 -> FETCH, DECODE, EXEC_R, ALU_WB; reg_we=1, reg_dst=1 in cycle 4.
REQ-039 lw with mem_ready low for 2 cycles in MEM_RD -> MEM_RD held 3 cycles, mem_re=1, iord=1 throughout, then MEM_WB with wb_src=1.
REQ-040 beq with zero=1 -> pc_we=1, pc_src=1 in BRANCH; bne with zero=1 -> pc_we=0.
REQ-041 xori -> ext_sel=0, alu_op=3 in EXEC_I; addi -> ext_sel=1, alu_op=0.
REQ-042 opcode 0x3F -> TRAP with illegal=1 held for 10 cycles; reset=1 -> FETCH next edge, illegal=0.
REQ-043 reset asserted during a MEM_WR wait -> FETCH next edge, mem_we=0.
